// File: rtl/branch_pred.sv
// Direct-mapped 2-bit BHT + BTB: zero-latency lookup, trained on resolved branches.
// Registered one-cycle mispredict pulse; saturating branch/mispredict statistics.
module branch_pred #(
  parameter int ENTRIES = 32,
  parameter int CNT_W   = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      fetch_pc,
  output logic             pred_hit,
  output logic             pred_taken,
  output logic [31:0]      pred_target,
  input  logic             update_valid,
  input  logic [31:0]      update_pc,
  input  logic [31:0]      update_target,
  input  logic             br_en,
  input  logic             update_pred_taken,
  input  logic [31:0]      update_pred_tgt,
  output logic             mispredict,
  output logic [CNT_W-1:0] branch_count,
  output logic [CNT_W-1:0] mispred_count
);

  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TAG_W = 30 - IDX_W;
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [ENTRIES-1:0] valid_q;
  logic [TAG_W-1:0]   tag_q    [ENTRIES];
  logic [31:0]        target_q [ENTRIES];
  logic [1:0]         ctr_q    [ENTRIES];

  logic [IDX_W-1:0] f_idx, u_idx;
  logic [TAG_W-1:0] f_tag, u_tag;
  logic             u_hit;
  logic             mis_cond;
  logic             unused_pc_bits;

  assign f_idx = fetch_pc[IDX_W+1:2];
  assign f_tag = fetch_pc[31:IDX_W+2];
  assign u_idx = update_pc[IDX_W+1:2];
  assign u_tag = update_pc[31:IDX_W+2];
  assign unused_pc_bits = ^{fetch_pc[1:0], update_pc[1:0]};

  // Lookup reads registered state only, so a same-cycle update is not bypassed.
  assign pred_hit    = valid_q[f_idx] && (tag_q[f_idx] == f_tag);
  assign pred_taken  = pred_hit && ctr_q[f_idx][1];
  assign pred_target = pred_taken ? target_q[f_idx] : (fetch_pc + 32'd4);

  assign u_hit    = valid_q[u_idx] && (tag_q[u_idx] == u_tag);
  assign mis_cond = update_valid &&
                    ((update_pred_taken != br_en) ||
                     (br_en && update_pred_taken && (update_pred_tgt != update_target)));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= '0;
      for (int i = 0; i < ENTRIES; i++) begin
        tag_q[i]    <= '0;
        target_q[i] <= '0;
        ctr_q[i]    <= 2'b01;
      end
    end else if (update_valid) begin
      if (u_hit) begin
        if (br_en) begin
          if (ctr_q[u_idx] != 2'b11) ctr_q[u_idx] <= ctr_q[u_idx] + 2'd1;
          target_q[u_idx] <= update_target;
        end else if (ctr_q[u_idx] != 2'b00) begin
          ctr_q[u_idx] <= ctr_q[u_idx] - 2'd1;
        end
      end else if (br_en) begin
        // Miss on a taken branch evicts whatever aliased into this slot.
        valid_q[u_idx]  <= 1'b1;
        tag_q[u_idx]    <= u_tag;
        target_q[u_idx] <= update_target;
        ctr_q[u_idx]    <= 2'b10;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mispredict    <= 1'b0;
      branch_count  <= '0;
      mispred_count <= '0;
    end else begin
      mispredict <= mis_cond;
      if (update_valid && (branch_count != {CNT_W{1'b1}}))
        branch_count <= branch_count + CNT_ONE;
      if (mis_cond && (mispred_count != {CNT_W{1'b1}}))
        mispred_count <= mispred_count + CNT_ONE;
    end
  end

endmodule

// File: tb/tb_branch_pred.sv
// Directed + randomized bench for branch_pred against a per-slot behavioural model.
module tb_branch_pred;
  localparam int ENTRIES = 32;
  localparam int IDX_W   = $clog2(ENTRIES);
  localparam int CNT_W   = 32;
  localparam longint CNT_MAX = 64'hFFFF_FFFF;

  logic             clk = 1'b0;
  logic             rst;
  logic [31:0]      fetch_pc;
  logic             pred_hit, pred_taken;
  logic [31:0]      pred_target;
  logic             update_valid;
  logic [31:0]      update_pc, update_target, update_pred_tgt;
  logic             br_en, update_pred_taken;
  logic             mispredict;
  logic [CNT_W-1:0] branch_count, mispred_count;

  always #5 clk = ~clk;

  branch_pred #(.ENTRIES(ENTRIES), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .fetch_pc(fetch_pc),
    .pred_hit(pred_hit), .pred_taken(pred_taken), .pred_target(pred_target),
    .update_valid(update_valid), .update_pc(update_pc), .update_target(update_target),
    .br_en(br_en), .update_pred_taken(update_pred_taken), .update_pred_tgt(update_pred_tgt),
    .mispredict(mispredict), .branch_count(branch_count), .mispred_count(mispred_count)
  );

  int total = 0;
  int bad   = 0;

  // Model: each slot remembers which branch (by upper PC bits) owns it and a strength 0..3.
  bit          m_valid [ENTRIES];
  logic [31:0] m_owner [ENTRIES];
  logic [31:0] m_tgt   [ENTRIES];
  int          m_str   [ENTRIES];
  longint      m_br, m_mis;
  logic        exp_mis;

  function automatic int slot(input logic [31:0] pc);
    return int'((pc >> 2) & (ENTRIES - 1));
  endfunction

  function automatic logic [31:0] owner(input logic [31:0] pc);
    return pc >> (IDX_W + 2);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < ENTRIES; i++) begin
      m_valid[i] = 0; m_owner[i] = 0; m_tgt[i] = 0; m_str[i] = 1;
    end
    m_br = 0; m_mis = 0; exp_mis = 1'b0;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    int i;
    bit h, t;
    logic [31:0] tg;
    #1;
    i  = slot(fetch_pc);
    h  = m_valid[i] && (m_owner[i] == owner(fetch_pc));
    t  = h && (m_str[i] >= 2);
    tg = t ? m_tgt[i] : fetch_pc + 32'd4;
    chk($sformatf("%s.hit", tag), pred_hit, h);
    chk($sformatf("%s.taken", tag), pred_taken, t);
    chk($sformatf("%s.target", tag), pred_target, tg);
    chk($sformatf("%s.mispredict", tag), mispredict, exp_mis);
    chk($sformatf("%s.branch_count", tag), branch_count, m_br);
    chk($sformatf("%s.mispred_count", tag), mispred_count, m_mis);
  endtask

  // Apply the presented update to the model, then cross the clock edge.
  task automatic tick();
    int i;
    bit h, mis;
    if (update_valid) begin
      mis = (update_pred_taken != br_en) || (br_en && update_pred_tgt != update_target);
      if (m_br < CNT_MAX) m_br++;
      if (mis && m_mis < CNT_MAX) m_mis++;
      exp_mis = mis;
      i = slot(update_pc);
      h = m_valid[i] && (m_owner[i] == owner(update_pc));
      if (h) begin
        m_str[i] = br_en ? ((m_str[i] < 3) ? m_str[i] + 1 : 3) : ((m_str[i] > 0) ? m_str[i] - 1 : 0);
        if (br_en) m_tgt[i] = update_target;
      end else if (br_en) begin
        m_valid[i] = 1; m_owner[i] = owner(update_pc); m_tgt[i] = update_target; m_str[i] = 2;
      end
    end else begin
      exp_mis = 1'b0;
    end
    @(posedge clk);
    #2;
  endtask

  task automatic set_upd(input logic [31:0] pc, input logic [31:0] tgt, input logic en,
                         input logic ptaken, input logic [31:0] ptgt);
    update_valid = 1'b1; update_pc = pc; update_target = tgt;
    br_en = en; update_pred_taken = ptaken; update_pred_tgt = ptgt;
  endtask

  task automatic upd(input logic [31:0] pc, input logic [31:0] tgt, input logic en,
                     input logic ptaken, input logic [31:0] ptgt);
    set_upd(pc, tgt, en, ptaken, ptgt);
    tick();
    update_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; fetch_pc = 32'h0; update_valid = 1'b0; update_pc = 32'h0;
    update_target = 32'h0; br_en = 1'b0; update_pred_taken = 1'b0; update_pred_tgt = 32'h0;
    model_reset();
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;

    fetch_pc = 32'h100;
    check_all("reset");

    upd(32'h100, 32'h80, 1'b1, 1'b0, 32'h0);
    check_all("alloc");
    chk("alloc.target_const", pred_target, 32'h80);
    tick();
    check_all("pulse_end");

    upd(32'h100, 32'h80, 1'b1, 1'b1, 32'h80);
    upd(32'h100, 32'h80, 1'b1, 1'b1, 32'h80);
    upd(32'h100, 32'h80, 1'b0, 1'b1, 32'h80);
    check_all("nt_once");
    chk("nt_once.taken_const", pred_taken, 1'b1);
    upd(32'h100, 32'h80, 1'b0, 1'b1, 32'h80);
    check_all("nt_twice");
    chk("nt_twice.target_const", pred_target, 32'h104);

    upd(32'h180, 32'h200, 1'b1, 1'b0, 32'h0);
    fetch_pc = 32'h100;
    check_all("alias_old");
    fetch_pc = 32'h180;
    check_all("alias_new");
    chk("alias_new.target_const", pred_target, 32'h200);

    set_upd(32'h180, 32'h200, 1'b0, 1'b1, 32'h200);
    check_all("same_pre");
    tick();
    update_valid = 1'b0;
    check_all("same_post");

    upd(32'h200, 32'h240, 1'b1, 1'b0, 32'h0);
    upd(32'h200, 32'h240, 1'b1, 1'b1, 32'h300);
    fetch_pc = 32'h200;
    check_all("tgt_mis");
    chk("tgt_mis.pulse_const", mispredict, 1'b1);

    for (int n = 0; n < 400; n++) begin
      logic [31:0] pc;
      pc = ($urandom_range(0, 3) << 7) | ($urandom_range(0, 3) << 2) | $urandom_range(0, 3);
      fetch_pc = ($urandom_range(0, 3) << 7) | ($urandom_range(0, 3) << 2) | $urandom_range(0, 3);
      if ($urandom_range(0, 9) < 6)
        set_upd(pc, 32'h1000 + ($urandom_range(0, 3) << 4), 1'($urandom_range(0, 1)),
                1'($urandom_range(0, 1)), 32'h1000 + ($urandom_range(0, 3) << 4));
      else
        update_valid = 1'b0;
      check_all("rnd");
      tick();
    end
    update_valid = 1'b0;

    upd(32'h100, 32'h80, 1'b1, 1'b0, 32'h0);
    upd(32'h100, 32'h80, 1'b1, 1'b1, 32'h80);
    fetch_pc = 32'h100;
    check_all("pre_rst");
    set_upd(32'h100, 32'h90, 1'b1, 1'b1, 32'h80);
    #1 rst = 1'b1;
    model_reset();
    check_all("mid_rst");
    @(posedge clk);
    #2 rst = 1'b0;
    update_valid = 1'b0;
    check_all("post_rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
